// File: rtl/fpu_dp_add_stage.sv
// Issue/retire stage around the combinational double-precision adder: resolves special operands
// itself, holds adder operands for SETTLE_CYCLES, then presents the result over valid/ready.
module fpu_dp_add_stage #(
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [63:0] QNAN          = 64'h7FF8_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_sub,
    output logic [63:0] adder_a,
    output logic [63:0] adder_b,
    input  logic [63:0] adder_result,
    input  logic        adder_overflow,
    input  logic        adder_underflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [3:0]  out_flags,
    output logic [2:0]  sticky_flags,
    input  logic        clear_sticky
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_counter;
    logic [63:0] r_adderA;
    logic [63:0] r_adderB;
    logic [63:0] r_result;
    logic [3:0]  r_flags;
    logic [2:0]  r_sticky;

    logic [63:0] w_bEff;
    logic        w_aNan, w_bNan, w_aInf, w_bInf, w_aZero, w_bZero;
    logic        w_accept;
    logic        w_handshake;
    logic        w_special;
    logic        w_specInvalid;
    logic [63:0] w_specResult;
    logic [63:0] w_capResult;
    logic [3:0]  w_capFlags;

    assign w_bEff  = {in_b[63] ^ in_sub, in_b[62:0]};
    assign w_aNan  = (in_a[62:52] == 11'h7FF) && (in_a[51:0] != 52'd0);
    assign w_bNan  = (w_bEff[62:52] == 11'h7FF) && (w_bEff[51:0] != 52'd0);
    assign w_aInf  = (in_a[62:52] == 11'h7FF) && (in_a[51:0] == 52'd0);
    assign w_bInf  = (w_bEff[62:52] == 11'h7FF) && (w_bEff[51:0] == 52'd0);
    // Denormals are flushed: any zero exponent counts as zero.
    assign w_aZero = (in_a[62:52] == 11'd0);
    assign w_bZero = (w_bEff[62:52] == 11'd0);

    assign in_ready    = rst_n & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
    assign w_accept    = in_valid & in_ready;
    assign out_valid   = (r_state == S_DONE);
    assign w_handshake = out_valid & out_ready;

    assign adder_a      = r_adderA;
    assign adder_b      = r_adderB;
    assign out_result   = r_result;
    assign out_flags    = r_flags;
    assign sticky_flags = r_sticky;

    always_comb begin
        w_special     = 1'b1;
        w_specInvalid = 1'b0;
        w_specResult  = 64'd0;
        if (w_aNan || w_bNan) begin
            w_specResult  = QNAN;
            w_specInvalid = 1'b1;
        end else if (w_aInf && w_bInf && (in_a[63] != w_bEff[63])) begin
            w_specResult  = QNAN;
            w_specInvalid = 1'b1;
        end else if (w_aInf) begin
            w_specResult = in_a;
        end else if (w_bInf) begin
            w_specResult = w_bEff;
        end else if (w_aZero && w_bZero) begin
            w_specResult = {in_a[63] & w_bEff[63], 63'd0};
        end else if (w_aZero) begin
            w_specResult = w_bEff;
        end else if (w_bZero) begin
            w_specResult = in_a;
        end else if ((in_a[62:0] == w_bEff[62:0]) && (in_a[63] != w_bEff[63])) begin
            w_specResult = 64'd0;
        end else begin
            w_special = 1'b0;
        end
    end

    // Overflow saturates to signed infinity and takes precedence over underflow.
    always_comb begin
        w_capResult = adder_result;
        w_capFlags  = 4'b0000;
        if (adder_overflow) begin
            w_capResult = {adder_result[63], 11'h7FF, 52'd0};
            w_capFlags  = 4'b0100;
        end else if (adder_underflow) begin
            w_capResult = {adder_result[63], 63'd0};
            w_capFlags  = 4'b0010;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_counter <= 4'd0;
            r_adderA  <= 64'd0;
            r_adderB  <= 64'd0;
            r_result  <= 64'd0;
            r_flags   <= 4'd0;
        end else if (w_accept) begin
            if (w_special) begin
                r_state  <= S_DONE;
                r_result <= w_specResult;
                r_flags  <= {w_specInvalid, 2'b00, 1'b1};
            end else begin
                r_state   <= S_ISSUE;
                r_adderA  <= in_a;
                r_adderB  <= w_bEff;
                r_counter <= CNT_INIT;
            end
        end else if (r_state == S_ISSUE) begin
            if (r_counter == 4'd0) begin
                r_state  <= S_DONE;
                r_result <= w_capResult;
                r_flags  <= w_capFlags;
            end else begin
                r_counter <= r_counter - 4'd1;
            end
        end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= 3'd0;
        end else if (clear_sticky) begin
            r_sticky <= 3'd0;
        end else if (w_handshake) begin
            r_sticky <= r_sticky | r_flags[3:1];
        end
    end

endmodule

// File: tb/tb_fpu_dp_add_stage.sv
// Directed bench for fpu_dp_add_stage: table of operand pairs with hand-computed results,
// plus sequences for backpressure, sticky clearing and reset during a settle window.
module tb_fpu_dp_add_stage;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] adderRes;
        logic        ovf;
        logic        unf;
        logic [63:0] expRes;
        logic [3:0]  expFlags;
        int          expLat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, rst_n3;
    logic        in_valid, in_valid3;
    logic        in_ready, in_ready3;
    logic [63:0] in_a, in_b;
    logic        in_sub;
    logic [63:0] adder_a, adder_b, adder_a3, adder_b3;
    logic [63:0] adderResult;
    logic        adderOverflow, adderUnderflow;
    logic        out_valid, out_valid3;
    logic        out_ready, out_ready3;
    logic [63:0] out_result, out_result3;
    logic [3:0]  out_flags, out_flags3;
    logic [2:0]  sticky_flags, sticky3;
    logic        clear_sticky;

    int compared = 0;
    int mismatched = 0;
    logic [2:0]  expSticky = 3'd0;
    logic [63:0] expA = 64'd0;
    logic [63:0] expB = 64'd0;
    vec_t vecs[13];

    always #5 clk = ~clk;

    fpu_dp_add_stage #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .adder_a(adder_a), .adder_b(adder_b), .adder_result(adderResult),
        .adder_overflow(adderOverflow), .adder_underflow(adderUnderflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .sticky_flags(sticky_flags), .clear_sticky(clear_sticky)
    );

    fpu_dp_add_stage #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .adder_a(adder_a3), .adder_b(adder_b3), .adder_result(adderResult),
        .adder_overflow(adderOverflow), .adder_underflow(adderUnderflow),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_result(out_result3),
        .out_flags(out_flags3), .sticky_flags(sticky3), .clear_sticky(clear_sticky)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic clr, input string tag);
        int lat;
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_sub = v.sub;
        adderResult = v.adderRes; adderOverflow = v.ovf; adderUnderflow = v.unf;
        out_ready = 1'b0; in_valid = 1'b1;
        #1 checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(v.expLat));
        checkOutput({tag, " result"}, out_result, v.expRes);
        checkOutput({tag, " flags"}, 64'(out_flags), 64'(v.expFlags));
        if (!v.expFlags[0]) begin
            expA = v.a;
            expB = {v.b[63] ^ v.sub, v.b[62:0]};
        end
        checkOutput({tag, " adder_a"}, adder_a, expA);
        checkOutput({tag, " adder_b"}, adder_b, expB);
        @(negedge clk);
        out_ready = 1'b1; clear_sticky = clr;
        @(posedge clk); #1;
        out_ready = 1'b0; clear_sticky = 1'b0;
        expSticky = clr ? 3'd0 : (expSticky | v.expFlags[3:1]);
        checkOutput({tag, " sticky"}, 64'(sticky_flags), 64'(expSticky));
        checkOutput({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic seen;
        vecs[0]  = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 64'h4008_0000_0000_0000, 1'b0, 1'b0,
                     64'h4008_0000_0000_0000, 4'b0000, 2};
        vecs[1]  = '{64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 1'b1, 64'h1111_0000_0000_0000, 1'b0, 1'b0,
                     64'h7FF8_0000_0000_0000, 4'b1001, 1};
        vecs[2]  = '{64'h0000_0000_0000_0000, 64'h4014_0000_0000_0000, 1'b0, 64'h2222_0000_0000_0000, 1'b0, 1'b0,
                     64'h4014_0000_0000_0000, 4'b0001, 1};
        vecs[3]  = '{64'h7FEF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                     64'h7FF0_0000_0000_0000, 4'b0100, 2};
        vecs[4]  = '{64'h0010_0000_0000_0001, 64'h8010_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0123, 1'b0, 1'b1,
                     64'h8000_0000_0000_0000, 4'b0010, 2};
        vecs[5]  = '{64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 1'b0, 64'h3333_0000_0000_0000, 1'b0, 1'b0,
                     64'h7FF8_0000_0000_0000, 4'b1001, 1};
        vecs[6]  = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 64'h4444_0000_0000_0000, 1'b0, 1'b0,
                     64'h8000_0000_0000_0000, 4'b0001, 1};
        vecs[7]  = '{64'h4014_0000_0000_0000, 64'h4014_0000_0000_0000, 1'b1, 64'h5555_0000_0000_0000, 1'b0, 1'b0,
                     64'h0000_0000_0000_0000, 4'b0001, 1};
        vecs[8]  = '{64'h3FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 1'b0, 64'h6666_0000_0000_0000, 1'b0, 1'b0,
                     64'hFFF0_0000_0000_0000, 4'b0001, 1};
        vecs[9]  = '{64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 1'b0, 64'h7777_0000_0000_0000, 1'b0, 1'b0,
                     64'h7FF0_0000_0000_0000, 4'b0001, 1};
        vecs[10] = '{64'h4000_0000_0000_0000, 64'h0000_0000_0000_0005, 1'b1, 64'h8888_0000_0000_0000, 1'b0, 1'b0,
                     64'h4000_0000_0000_0000, 4'b0001, 1};
        vecs[11] = '{64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0, 1'b0,
                     64'h4000_0000_0000_0000, 4'b0000, 2};
        vecs[12] = '{64'h7FE0_0000_0000_0000, 64'h7FE0_0000_0000_0000, 1'b0, 64'h8123_4567_89AB_CDEF, 1'b1, 1'b1,
                     64'hFFF0_0000_0000_0000, 4'b0100, 2};

        rst_n = 1'b0; rst_n3 = 1'b0;
        in_valid = 1'b0; in_valid3 = 1'b0; out_ready = 1'b0; out_ready3 = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0; clear_sticky = 1'b0;
        adderResult = '0; adderOverflow = 1'b0; adderUnderflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset out_result", out_result, 64'd0);
        checkOutput("reset out_flags", 64'(out_flags), 64'd0);
        checkOutput("reset sticky", 64'(sticky_flags), 64'd0);
        checkOutput("reset adder_a", adder_a, 64'd0);
        checkOutput("reset adder_b", adder_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; rst_n3 = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Sticky holds all three bits here; clearing on the handshake must win.
        applyStimulus(vecs[3], 1'b1, "clear_sticky");

        // Backpressure, then a bypass op accepted in the same cycle as the release.
        @(negedge clk);
        in_a = vecs[0].a; in_b = vecs[0].b; in_sub = 1'b0;
        adderResult = vecs[0].adderRes; adderOverflow = 1'b0; adderUnderflow = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp latency", 64'(lat), 64'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp hold result c%0d", c), out_result, 64'h4008_0000_0000_0000);
            checkOutput($sformatf("bp in_ready c%0d", c), 64'(in_ready), 64'd0);
            checkOutput($sformatf("bp out_valid c%0d", c), 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        in_a = 64'h0; in_b = 64'h4014_0000_0000_0000; in_sub = 1'b0;
        #1 checkOutput("bp release in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checkOutput("b2b out_valid", 64'(out_valid), 64'd1);
        checkOutput("b2b result", out_result, 64'h4014_0000_0000_0000);
        checkOutput("b2b flags", 64'(out_flags), 64'h1);
        checkOutput("b2b adder_a kept", adder_a, 64'h3FF0_0000_0000_0000);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("b2b drain out_valid", 64'(out_valid), 64'd0);
        checkOutput("b2b sticky", 64'(sticky_flags), 64'd0);

        // Reset while the SETTLE_CYCLES=3 instance is mid-settle.
        @(negedge clk);
        in_a = vecs[0].a; in_b = vecs[0].b; in_sub = 1'b0;
        adderResult = vecs[0].adderRes;
        in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        checkOutput("s3 issued adder_a", adder_a3, 64'h3FF0_0000_0000_0000);
        @(posedge clk); #1;
        checkOutput("s3 settling out_valid", 64'(out_valid3), 64'd0);
        @(negedge clk);
        rst_n3 = 1'b0;
        @(posedge clk); #1;
        checkOutput("s3 reset out_valid", 64'(out_valid3), 64'd0);
        checkOutput("s3 reset adder_a", adder_a3, 64'd0);
        checkOutput("s3 reset adder_b", adder_b3, 64'd0);
        checkOutput("s3 reset in_ready", 64'(in_ready3), 64'd0);
        @(negedge clk);
        rst_n3 = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            seen = seen | out_valid3;
        end
        checkOutput("s3 abandoned op emitted", 64'(seen), 64'd0);
        @(negedge clk);
        in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        lat = 1;
        while (!out_valid3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("s3 latency", 64'(lat), 64'd4);
        checkOutput("s3 result", out_result3, 64'h4008_0000_0000_0000);
        checkOutput("s3 flags", 64'(out_flags3), 64'd0);
        @(negedge clk);
        out_ready3 = 1'b1;
        @(posedge clk); #1;
        out_ready3 = 1'b0;
        checkOutput("s3 drain out_valid", 64'(out_valid3), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
